// File: rtl/add4_pkg.sv
// add4_pkg: shared types and constants for the burst accumulator.
//   state_t   - sequencer FSM states
//   N_OPS_DEF - default number of operands per burst
//   nibble_t  - 4-bit operand / sum type
package add4_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int N_OPS_DEF = 4;
    typedef logic [3:0] nibble_t;
endpackage

// File: rtl/acc4_sequencer_if.sv
// acc4_sequencer_if: operand input and result output handshakes.
//   in_data/in_valid/in_ready              - operand stream into the sequencer
//   out_sum/out_carry_cnt/out_overflow,
//   out_valid/out_ready                    - burst result stream out of it
//   master: the side that feeds operands and consumes results
//   slave:  the sequencer itself
interface acc4_sequencer_if
    import add4_pkg::*;
#(
    parameter int CW = 3
);
    nibble_t       in_data;
    logic          in_valid;
    logic          in_ready;
    nibble_t       out_sum;
    logic [CW-1:0] out_carry_cnt;
    logic          out_overflow;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_carry_cnt, out_overflow, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sum, out_carry_cnt, out_overflow, out_valid
    );
endinterface

// File: rtl/bit_4_adder.sv
// bit_4_adder: 4-bit adder with carry out.
//   A, B  - operands
//   SUM   - low 4 bits of A+B
//   C_out - carry out of bit 3
module bit_4_adder
    import add4_pkg::*;
(
    input  nibble_t A,
    input  nibble_t B,
    output nibble_t SUM,
    output logic    C_out
);
    assign {C_out, SUM} = {1'b0, A} + {1'b0, B};
endmodule

// File: rtl/acc4_sequencer.sv
// acc4_sequencer: sums bursts of N_OPS 4-bit operands and presents the total.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of acc4_sequencer_if (operand in, result out)
// The total is reported as out_sum (low nibble) plus out_carry_cnt, the count
// of adder carries, which equals the upper bits of the total.
module acc4_sequencer
    import add4_pkg::*;
#(
    parameter int N_OPS = N_OPS_DEF,
    parameter int CW    = $clog2(N_OPS + 1)
) (
    input logic             clk,
    input logic             rst_n,
    acc4_sequencer_if.slave bus
);
    localparam int OW = $clog2(N_OPS + 1);

    state_t        state;
    nibble_t       acc;
    nibble_t       sum;
    nibble_t       out_sum_q;
    logic          c_out;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_ovf_q;
    logic [CW-1:0] carry_cnt;
    logic [CW-1:0] carry_nxt;
    logic [CW-1:0] out_carry_q;
    logic [OW-1:0] op_cnt;
    logic          accept;
    logic          last;

    bit_4_adder u_add (
        .A     (acc),
        .B     (bus.in_data),
        .SUM   (sum),
        .C_out (c_out)
    );

    assign carry_nxt = carry_cnt + CW'(c_out);
    assign accept    = bus.in_valid && in_ready_q;
    assign last      = op_cnt == OW'(N_OPS - 1);

    // Result registers are separate from the accumulator so the out_* ports
    // stay at zero while a burst is still being summed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            carry_cnt   <= '0;
            op_cnt      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (state == DONE) begin
            if (bus.out_ready) begin
                state       <= IDLE;
                acc         <= '0;
                carry_cnt   <= '0;
                op_cnt      <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
                out_sum_q   <= '0;
                out_carry_q <= '0;
                out_ovf_q   <= 1'b0;
            end
        end else if (accept) begin
            acc         <= sum;
            carry_cnt   <= carry_nxt;
            op_cnt      <= op_cnt + 1'b1;
            state       <= last ? DONE : ACCUM;
            in_ready_q  <= !last;
            out_valid_q <= last;
            if (last) begin
                out_sum_q   <= sum;
                out_carry_q <= carry_nxt;
                out_ovf_q   <= |carry_nxt;
            end
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_sum       = out_sum_q;
    assign bus.out_carry_cnt = out_carry_q;
    assign bus.out_overflow  = out_ovf_q;
endmodule

// File: tb/tb_acc4_sequencer.sv
// tb_acc4_sequencer: checks N_OPS=4 and N_OPS=1 sequencers against a burst-total model.
module tb_acc4_sequencer;
    import add4_pkg::*;

    localparam int NOPS [2] = '{4, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_data = 4'd0;

    int pass_cnt = 0;
    int check_cnt = 0;
    bit chk_on = 1'b0;

    int m_cnt [2];
    int m_tot [2];
    bit m_done [2];

    logic [3:0] o_sum [2];
    logic [2:0] o_cc [2];
    logic       o_ovf [2];
    logic       o_val [2];
    logic       o_ir [2];

    always #5 clk = ~clk;

    acc4_sequencer_if #(.CW(3)) bus4 ();
    acc4_sequencer_if #(.CW(1)) bus1 ();

    assign bus4.in_data   = in_data;
    assign bus4.in_valid  = in_valid;
    assign bus4.out_ready = out_ready;
    assign bus1.in_data   = in_data;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;

    assign o_sum[0] = bus4.out_sum;
    assign o_cc[0]  = bus4.out_carry_cnt;
    assign o_ovf[0] = bus4.out_overflow;
    assign o_val[0] = bus4.out_valid;
    assign o_ir[0]  = bus4.in_ready;
    assign o_sum[1] = bus1.out_sum;
    assign o_cc[1]  = {2'b00, bus1.out_carry_cnt};
    assign o_ovf[1] = bus1.out_overflow;
    assign o_val[1] = bus1.out_valid;
    assign o_ir[1]  = bus1.in_ready;

    acc4_sequencer #(.N_OPS(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    acc4_sequencer #(.N_OPS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input int k, input string name, input int act, input int exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL N_OPS=%0d %s: got %0d expected %0d at %0t", NOPS[k], name, act, exp, $time);
    endtask

    // Model: a burst is just a running total and an operand count; the result
    // is total%16 and total/16 once N operands have been taken.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_cnt[k] = 0; m_tot[k] = 0; m_done[k] = 1'b0;
            end else if (m_done[k]) begin
                if (out_ready) begin
                    m_cnt[k] = 0; m_tot[k] = 0; m_done[k] = 1'b0;
                end
            end else if (in_valid) begin
                m_tot[k] += int'(in_data);
                m_cnt[k]++;
                m_done[k] = (m_cnt[k] == NOPS[k]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                check(k, "out_valid", int'(o_val[k]), int'(m_done[k]));
                check(k, "in_ready", int'(o_ir[k]), int'(!m_done[k]));
                check(k, "out_sum", int'(o_sum[k]), m_done[k] ? m_tot[k] % 16 : 0);
                check(k, "out_carry_cnt", int'(o_cc[k]), m_done[k] ? m_tot[k] / 16 : 0);
                check(k, "out_overflow", int'(o_ovf[k]), int'(m_done[k] && m_tot[k] >= 16));
            end
        end
    end

    task automatic cyc(input bit v, input int d, input bit r);
        in_valid  = v;
        in_data   = 4'(d);
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic burst4(input int a, input int b, input int c, input int d);
        cyc(1, a, 0); cyc(1, b, 0); cyc(1, c, 0); cyc(1, d, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            check(k, "reset out_valid", int'(o_val[k]), 0);
            check(k, "reset in_ready", int'(o_ir[k]), 1);
            check(k, "reset out_sum", int'(o_sum[k]), 0);
            check(k, "reset out_carry_cnt", int'(o_cc[k]), 0);
        end
        rst_n  = 1'b1;
        chk_on = 1'b1;
        cyc(0, 0, 0);

        burst4(9, 7, 3, 14);
        check(0, "9,7,3,14 out_valid", int'(o_val[0]), 1);
        check(0, "9,7,3,14 out_sum", int'(o_sum[0]), 1);
        check(0, "9,7,3,14 out_carry_cnt", int'(o_cc[0]), 2);
        check(0, "9,7,3,14 out_overflow", int'(o_ovf[0]), 1);

        repeat (5) cyc(1, 5, 0);
        check(0, "stall out_sum", int'(o_sum[0]), 1);
        check(0, "stall out_carry_cnt", int'(o_cc[0]), 2);
        check(0, "stall in_ready", int'(o_ir[0]), 0);
        cyc(1, 5, 1);
        check(0, "release out_valid", int'(o_val[0]), 0);
        check(0, "release in_ready", int'(o_ir[0]), 1);
        check(0, "release out_sum", int'(o_sum[0]), 0);
        burst4(1, 1, 1, 1);
        check(0, "1,1,1,1 out_sum", int'(o_sum[0]), 4);
        cyc(0, 0, 1);

        burst4(15, 15, 15, 15);
        check(0, "15x4 out_sum", int'(o_sum[0]), 12);
        check(0, "15x4 out_carry_cnt", int'(o_cc[0]), 3);
        cyc(0, 0, 1);

        for (int i = 1; i <= 4; i++) begin
            cyc(1, i, 0);
            if (i < 4) begin
                check(0, "gapped early out_valid", int'(o_val[0]), 0);
                repeat (3) cyc(0, 0, 0);
            end
        end
        check(0, "gapped out_valid", int'(o_val[0]), 1);
        check(0, "gapped out_sum", int'(o_sum[0]), 10);
        check(0, "gapped out_carry_cnt", int'(o_cc[0]), 0);
        check(0, "gapped out_overflow", int'(o_ovf[0]), 0);
        cyc(0, 0, 1);

        cyc(1, 9, 0);
        cyc(1, 7, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check(k, "async reset out_valid", int'(o_val[k]), 0);
            check(k, "async reset out_sum", int'(o_sum[k]), 0);
            check(k, "async reset in_ready", int'(o_ir[k]), 1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        burst4(2, 2, 2, 2);
        check(0, "post-reset out_sum", int'(o_sum[0]), 8);
        check(0, "post-reset out_carry_cnt", int'(o_cc[0]), 0);
        cyc(0, 0, 1);

        cyc(1, 6, 0);
        check(1, "single out_valid", int'(o_val[1]), 1);
        check(1, "single out_sum", int'(o_sum[1]), 6);
        check(1, "single in_ready", int'(o_ir[1]), 0);
        cyc(0, 0, 1);
        check(1, "single in_ready after release", int'(o_ir[1]), 1);
        check(1, "single out_valid after release", int'(o_val[1]), 0);

        repeat (800) cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);

        #1;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/acc4_sequencer.md
ACC4_SEQUENCER -- requirements
Module: acc4_sequencer

Interface
REQ-001 Parameter: N_OPS, default 4, number of 4-bit operands summed per burst; legal range 1..15.
REQ-002 Parameter: CW, default $clog2(N_OPS+1), width of the carry count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  4  operand value.
REQ-006 in_valid  input  1  operand present on in_data.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 out_sum  output  4  low 4 bits of the burst total.
REQ-009 out_carry_cnt  output  CW  number of adder carries in the burst, which equals the upper bits of the total.
REQ-010 out_overflow  output  1  set when out_carry_cnt != 0.
REQ-011 out_valid  output  1  result present on the out_* ports.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 FSM states SHALL be IDLE (no operand taken), ACCUM (1..N_OPS-1 taken) and DONE (result held).
REQ-014 Operand accept SHALL occur on in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-015 On accept: acc <= acc + in_data (mod 16) and carry_cnt <= carry_cnt + C_out, both computed through the 4-bit adder sub-module.
REQ-016 On accept: op_cnt increments.
REQ-017 On accept, the next state SHALL be DONE when op_cnt == N_OPS-1 and ACCUM otherwise.
REQ-018 With N_OPS=1, the state SHALL go IDLE->DONE on the first accept.
REQ-019 out_valid SHALL be 1 exactly in DONE; first assertion SHALL be the cycle after the Nth accept (latency 1).
REQ-020 out_sum, out_carry_cnt and out_overflow SHALL be driven from registers and held stable while out_valid && !out_ready.
REQ-021 On out_valid && out_ready: state <= IDLE; acc, carry_cnt and op_cnt clear to 0; in_ready returns to 1 the next cycle; no operand is accepted in the same cycle.
REQ-022 in_valid during DONE SHALL be ignored and SHALL NOT alter any state.
REQ-023 in_valid low during ACCUM SHALL stall with all state held; gaps of any length are legal.
REQ-024 carry_cnt SHALL NOT wrap; the maximum value N_OPS-1 fits in CW bits.
REQ-025 out_* SHALL read 0 whenever out_valid is 0.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE and acc=carry_cnt=op_cnt=0.
REQ-027 During reset, outputs SHALL be: out_valid=0, out_sum=0, out_carry_cnt=0, out_overflow=0, in_ready=1.
REQ-028 Reset asserted mid-burst SHALL discard all partial results; the first accept after deassertion SHALL start a new burst.
REQ-029 Reset deassertion SHALL take effect on the next rising clk edge.

Structure
REQ-030 Shared package add4_pkg SHALL hold: the state enum (IDLE, ACCUM, DONE), the N_OPS default constant, and the 4-bit operand typedef.
REQ-031 One sub-module SHALL be used: bit_4_adder, instantiated once with ports A=acc, B=in_data, SUM, C_out, and no other arithmetic in the datapath.

Verification
REQ-032 N_OPS=4, operands 9,7,3,14 back-to-back -> one cycle after the 4th accept: out_sum=0001, out_carry_cnt=2, out_overflow=1.
REQ-033 N_OPS=4, operands 15,15,15,15 -> out_sum=1100, out_carry_cnt=3 (total 60).
REQ-034 N_OPS=4, operands 1,2,3,4 with in_valid low 3 cycles between each -> out_sum=1010, out_carry_cnt=0, out_overflow=0; no early out_valid.
REQ-035 After REQ-032, out_ready held low 5 cycles with in_valid=1, in_data=5 -> outputs stable, in_ready=0; next burst 1,1,1,1 -> out_sum=0100.
REQ-036 Accept 9,7, then pulse rst_n low mid-cycle -> outputs clear immediately; next burst 2,2,2,2 -> out_sum=1000, out_carry_cnt=0.
REQ-037 N_OPS=1, operand 6 -> out_valid on the next cycle with out_sum=0110; out_ready=1 -> in_ready=1 the following cycle.
